// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants and helpers for the 4-digit 7-segment scan controller.
//   NUM_DIGITS   : digits on the display
//   AN_ALL_OFF   : anode pattern with every (active-low) digit dark
//   scan_state_e : scan FSM states
//   one_cold()   : active-low anode pattern selecting a single digit
package seg7_scan_ctrl_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] AN_ALL_OFF = 4'b1111;

  typedef enum logic {
    ST_BLANK   = 1'b0,
    ST_DISPLAY = 1'b1
  } scan_state_e;

  function automatic logic [3:0] one_cold(input logic [1:0] idx);
    one_cold = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_scan_slot_timer.sv
// Slot sequencer for the scan controller: alternates a dark dead-time
// (BLANK) and a lit period (DISPLAY) for each digit in turn.
//   clk, reset    : clock, asynchronous active-high reset
//   enter_display : high in the cycle whose rising edge enters DISPLAY
//   enter_blank   : high in the cycle whose rising edge leaves DISPLAY
//   frame_edge    : enter_display for digit 0 (frame boundary)
//   idx           : current digit index; advances on entry to DISPLAY
module seg7_scan_ctrl_scan_slot_timer
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  output logic       enter_display,
  output logic       enter_blank,
  output logic       frame_edge,
  output logic [1:0] idx
);

  localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 1'b1;
    idx_d         = idx_q;
    enter_display = 1'b0;
    enter_blank   = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d         = '0;
          idx_d         = idx_q + 2'd1;
          state_d       = ST_DISPLAY;
          enter_display = 1'b1;
        end
      end
      ST_DISPLAY: begin
        if (cnt_q == REFRESH_LAST) begin
          cnt_d       = '0;
          state_d     = ST_BLANK;
          enter_blank = 1'b1;
        end
      end
    endcase
    frame_edge = enter_display && (idx_d == 2'd0);
  end

  // idx resets to 3 so the first slot after reset lands on digit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign idx = idx_q;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode display.
// Loads are captured into shadow registers and promoted to the active set
// only at a frame boundary, so a frame never shows a mix of old and new.
//   clk, reset : clock, asynchronous active-high reset
//   load       : strobe capturing data/blank/dp
//   data       : four hex digits, [3:0] = rightmost digit 0
//   blank      : per-digit blank mask (1 = dark)
//   dp         : per-digit decimal point (1 = lit)
//   nibble     : selected digit value for the external hex_to_7seg decoder
//   an         : active-low anode enables, an[i] = digit i
//   dp_n       : active-low decimal point
//   frame      : one-cycle pulse when digit 0 becomes current
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [15:0]           data,
  input  logic [NUM_DIGITS-1:0] blank,
  input  logic [NUM_DIGITS-1:0] dp,
  output logic [3:0]            nibble,
  output logic [3:0]            an,
  output logic                  dp_n,
  output logic                  frame
);

  logic       enter_display, enter_blank, frame_edge;
  logic [1:0] idx, disp_idx;

  seg7_scan_ctrl_scan_slot_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .enter_display (enter_display),
    .enter_blank   (enter_blank),
    .frame_edge    (frame_edge),
    .idx           (idx)
  );

  logic [15:0]           sh_data_q, sh_data_d, act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [3:0]            nibble_q, nibble_d, an_q, an_d;
  logic                  dp_n_q, dp_n_d, frame_q, frame_d;

  // Index of the digit about to be displayed (timer advances idx on entry).
  assign disp_idx = idx + 2'd1;

  always_comb begin
    sh_data_d   = load ? data  : sh_data_q;
    sh_blank_d  = load ? blank : sh_blank_q;
    sh_dp_d     = load ? dp    : sh_dp_q;

    act_data_d  = act_data_q;
    act_blank_d = act_blank_q;
    act_dp_d    = act_dp_q;
    // A load landing on the boundary edge bypasses the shadow so the new
    // value is already visible on digit 0 of this frame.
    if (frame_edge) begin
      act_data_d  = load ? data  : sh_data_q;
      act_blank_d = load ? blank : sh_blank_q;
      act_dp_d    = load ? dp    : sh_dp_q;
    end

    nibble_d = nibble_q;
    an_d     = an_q;
    dp_n_d   = dp_n_q;
    if (enter_display) begin
      nibble_d = act_data_d[{disp_idx, 2'b00} +: 4];
      an_d     = act_blank_d[disp_idx] ? AN_ALL_OFF : one_cold(disp_idx);
      dp_n_d   = act_blank_d[disp_idx] | ~act_dp_d[disp_idx];
    end else if (enter_blank) begin
      an_d   = AN_ALL_OFF;
      dp_n_d = 1'b1;
    end

    frame_d = frame_edge;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_data_q   <= 16'h0000;
      sh_blank_q  <= 4'b1111;
      sh_dp_q     <= 4'b0000;
      act_data_q  <= 16'h0000;
      act_blank_q <= 4'b1111;
      act_dp_q    <= 4'b0000;
      nibble_q    <= 4'h0;
      an_q        <= AN_ALL_OFF;
      dp_n_q      <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      sh_data_q   <= sh_data_d;
      sh_blank_q  <= sh_blank_d;
      sh_dp_q     <= sh_dp_d;
      act_data_q  <= act_data_d;
      act_blank_q <= act_blank_d;
      act_dp_q    <= act_dp_d;
      nibble_q    <= nibble_d;
      an_q        <= an_d;
      dp_n_q      <= dp_n_d;
      frame_q     <= frame_d;
    end
  end

  assign nibble = nibble_q;
  assign an     = an_q;
  assign dp_n   = dp_n_q;
  assign frame  = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with REFRESH_DIV=4, BLANK_CYCLES=2
// (slot 6 cycles, frame 24 cycles).
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] data;
  logic [3:0]  blank;
  logic [3:0]  dp;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        dp_n;
  logic        frame;

  int errors = 0;
  int checks = 0;

  seg7_scan_ctrl #(
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .data   (data),
    .blank  (blank),
    .dp     (dp),
    .nibble (nibble),
    .an     (an),
    .dp_n   (dp_n),
    .frame  (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Call positioned at edge 0 after reset release; display must stay dark,
  // frame pulses at edges 2, 26 and 50.
  task automatic idle_check(input string tag, input int n);
    for (int e = 1; e <= n; e++) begin
      tick();
      chk({tag, ".an"}, an, 4'hF);
      chk({tag, ".dp_n"}, {3'b0, dp_n}, 4'h1);
      chk({tag, ".frame"}, {3'b0, frame}, (e == 2 || e == 26 || e == 50) ? 4'h1 : 4'h0);
    end
  endtask

  // One 6-cycle slot: 4 lit cycles then 2 dark ones. Call positioned on the
  // last BLANK cycle of the previous slot. load pulses on iteration ld_cyc.
  task automatic run_digit(input string tag, input logic [3:0] nib,
                           input logic [3:0] an_e, input logic dpn,
                           input logic fr, input int ld_cyc);
    for (int j = 0; j < 6; j++) begin
      load = (j == ld_cyc);
      tick();
      load = 1'b0;
      chk({tag, ".nibble"}, nibble, nib);
      if (j < 4) begin
        chk({tag, ".an"}, an, an_e);
        chk({tag, ".dp_n"}, {3'b0, dp_n}, {3'b0, dpn});
        chk({tag, ".frame"}, {3'b0, frame}, {3'b0, (j == 0) ? fr : 1'b0});
      end else begin
        chk({tag, ".an_dark"}, an, 4'hF);
        chk({tag, ".dp_n_dark"}, {3'b0, dp_n}, 4'h1);
        chk({tag, ".frame"}, {3'b0, frame}, 4'h0);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    data  = 16'h0000;
    blank = 4'b0000;
    dp    = 4'b0000;

    // Reset values
    #12;
    chk("rst.nibble", nibble, 4'h0);
    chk("rst.an", an, 4'hF);
    chk("rst.dp_n", {3'b0, dp_n}, 4'h1);
    chk("rst.frame", {3'b0, frame}, 4'h0);

    // 1: idle after reset
    @(posedge clk);
    #1 reset = 1'b0;
    idle_check("idle1", 50);

    // 2: load 1A3F at edge 1, first frame shows it
    reset = 1'b1;
    #1;
    data  = 16'h1A3F;
    blank = 4'b0000;
    dp    = 4'b0100;
    load  = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    load = 1'b0;
    run_digit("f1d0", 4'hF, 4'b1110, 1'b1, 1'b1, -1);
    run_digit("f1d1", 4'h3, 4'b1101, 1'b1, 1'b0, -1);
    run_digit("f1d2", 4'hA, 4'b1011, 1'b0, 1'b0, -1);
    run_digit("f1d3", 4'h1, 4'b0111, 1'b1, 1'b0, -1);

    // 3: reload during digit-1 display; current frame unaffected
    run_digit("f2d0", 4'hF, 4'b1110, 1'b1, 1'b1, -1);
    data = 16'hBEEF;
    dp   = 4'b0000;
    run_digit("f2d1", 4'h3, 4'b1101, 1'b1, 1'b0, 2);
    run_digit("f2d2", 4'hA, 4'b1011, 1'b0, 1'b0, -1);
    run_digit("f2d3", 4'h1, 4'b0111, 1'b1, 1'b0, -1);
    run_digit("f3d0", 4'hF, 4'b1110, 1'b1, 1'b1, -1);
    run_digit("f3d1", 4'hE, 4'b1101, 1'b1, 1'b0, -1);
    run_digit("f3d2", 4'hE, 4'b1011, 1'b1, 1'b0, -1);
    run_digit("f3d3", 4'hB, 4'b0111, 1'b1, 1'b0, -1);

    // 4: load exactly on the frame-boundary edge shows in the same frame
    data = 16'h0007;
    dp   = 4'b0001;
    run_digit("f4d0", 4'h7, 4'b1110, 1'b0, 1'b1, 0);
    run_digit("f4d1", 4'h0, 4'b1101, 1'b1, 1'b0, -1);
    run_digit("f4d2", 4'h0, 4'b1011, 1'b1, 1'b0, -1);

    // 5: blank digit 3; slot timing and frame period unchanged
    data  = 16'h1234;
    blank = 4'b1000;
    dp    = 4'b0000;
    run_digit("f4d3", 4'h0, 4'b0111, 1'b1, 1'b0, 1);
    run_digit("f5d0", 4'h4, 4'b1110, 1'b1, 1'b1, -1);
    run_digit("f5d1", 4'h3, 4'b1101, 1'b1, 1'b0, -1);
    run_digit("f5d2", 4'h2, 4'b1011, 1'b1, 1'b0, -1);
    run_digit("f5d3", 4'h1, 4'b1111, 1'b1, 1'b0, -1);
    run_digit("f6d0", 4'h4, 4'b1110, 1'b1, 1'b1, -1);
    run_digit("f6d1", 4'h3, 4'b1101, 1'b1, 1'b0, -1);

    // 6: asynchronous reset in the middle of digit-2 display
    tick();
    tick();
    chk("mid.an", an, 4'b1011);
    chk("mid.nibble", nibble, 4'h2);
    #1 reset = 1'b1;
    #1;
    chk("arst.nibble", nibble, 4'h0);
    chk("arst.an", an, 4'hF);
    chk("arst.dp_n", {3'b0, dp_n}, 4'h1);
    chk("arst.frame", {3'b0, frame}, 4'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle_check("idle2", 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for the 4-digit common-anode 7-segment display on the Spartan3E board. It latches a 16-bit value plus per-digit blank and decimal-point masks, then cycles through the four digits. Each digit slot has a lit period followed by a dark dead-time period. The block drives the active-low anodes and decimal point, and supplies the selected 4-bit nibble to the existing combinational `hex_to_7seg` decoder, whose output drives the segment pins directly.

## Interface
- `REFRESH_DIV`, 50000: lit cycles per digit slot; legal range ≥ 1. At 50 MHz this gives 1 ms per digit.
- `BLANK_CYCLES`, 16: dark (anti-ghosting) cycles after each lit period; legal range ≥ 1.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; forces all state and outputs to reset values immediately.
- `load`  in  1  one-cycle strobe that captures `data`, `blank`, `dp` into the shadow registers.
- `data`  in  16  four hex digits; `[3:0]` = digit 0 (rightmost).
- `blank`  in  4  per-digit blank mask; 1 = digit stays dark for its whole slot.
- `dp`  in  4  per-digit decimal point; 1 = lit.
- `nibble`  out  4  selected digit value; connects to the `In` port of `hex_to_7seg`.
- `an`  out  4  anode enables, active-low; `an[i]` corresponds to digit i.
- `dp_n`  out  1  decimal point, active-low.
- `frame`  out  1  one-cycle pulse asserted on the cycle digit 0 becomes current.

## Operation
- Two-state FSM: BLANK and DISPLAY. A shared slot counter `cnt` and a 2-bit digit index `idx` sequence the scan.
- BLANK:
  - `an` = 4'b1111 and `dp_n` = 1.
  - `cnt` counts 0..BLANK_CYCLES-1.
  - At terminal count: `idx` <= `idx`+1 (3 wraps to 0), `cnt` <= 0, go to DISPLAY.
- DISPLAY:
  - `cnt` counts 0..REFRESH_DIV-1.
  - At terminal count: `cnt` <= 0, go to BLANK; `idx` is held.
- On the edge that enters DISPLAY, the outputs register from the active registers:
  - `nibble` <= active_data[4*idx' +: 4], where idx' is the new index.
  - `an` <= one-cold(idx'), or 4'b1111 if active_blank[idx'] = 1.
  - `dp_n` <= ~active_dp[idx'], or 1 if the digit is blanked.
  - These values hold for the whole DISPLAY period.
- `nibble` holds its last value through BLANK. A blanked digit still consumes its full slot time.
- Shadow/active double buffering, to prevent a mid-frame tear:
  - `load` writes the shadow registers on any cycle.
  - Shadow is copied to active only on the frame-boundary edge, i.e. the BLANK→DISPLAY edge with idx' = 0. `frame` is 1 for the cycle that follows this edge.
  - If `load` coincides with the frame-boundary edge, `data`/`blank`/`dp` go straight into active (bypassing the shadow) and into the shadow.
  - Back-to-back loads: the last one before the boundary wins.
- Reset values:
  - FSM = BLANK, `cnt` = 0, `idx` = 3.
  - Shadow and active: data = 16'h0000, blank = 4'b1111, dp = 4'b0000.
  - Outputs: `nibble` = 0, `an` = 4'b1111, `dp_n` = 1, `frame` = 0.
  - The display is therefore dark until the first load is displayed.

## Timing
- Slot = REFRESH_DIV + BLANK_CYCLES cycles. Frame = 4 × slot.
- After reset deasserts, the first DISPLAY (digit 0) begins at edge BLANK_CYCLES, counting the first edge after deassert as edge 1. `frame` pulses then, and every frame thereafter.
- Display latency of a `load`: 1 to 4 × slot cycles, with the update always at a frame boundary.
- Reset asserted mid-slot: outputs go to reset values asynchronously. The scan restarts from BLANK with `idx` = 3, and shadow contents are lost.
- Counter width is `$clog2(max(REFRESH_DIV, BLANK_CYCLES))`. There is no free-running overflow; the counter always reloads to 0 at its terminal count.

## Structure
- Shared constants header `seg7_defs`: `AN_ALL_OFF` = 4'b1111, `NUM_DIGITS` = 4, and the one-cold anode encoding function.
- One natural sub-module: `scan_slot_timer`. It contains the FSM, `cnt` and `idx`, and emits `enter_display`, `frame_edge` and `idx`.
- The top level contains the shadow/active registers and the output registers.
- `hex_to_7seg` is instantiated by the board top level, not inside this block.

## Test plan
All scenarios use REFRESH_DIV=4 and BLANK_CYCLES=2 (slot 6, frame 24).
1. Reset, then 50 idle cycles → `an` = 4'b1111 and `dp_n` = 1 throughout; `frame` pulses at edges 2, 26 and 50.
2. `load` with data=16'h1A3F, blank=0, dp=4'b0100 at cycle 0:
   - Digits show `nibble` F, 3, A, 1 on `an` 1110, 1101, 1011, 0111, each for 4 cycles, separated by 2 cycles of 1111.
   - `dp_n` = 0 only during the digit-2 slot.
3. Mid-frame reload during the digit-1 slot with data=16'hBEEF → digits 2 and 3 of the current frame still show A and 1; the next frame shows F, E, E, B.
4. `load` of 16'h0007 on the exact frame-boundary edge → digit 0 of that same frame shows 7.
5. blank=4'b1000 with data=16'h1234 → `an[3]` is never 0; the digit-3 slot is still 6 cycles; the frame period stays 24.
6. Assert `reset` mid digit-2 DISPLAY → `an` = 1111, `dp_n` = 1, `nibble` = 0 before the next edge; after release the display stays dark (shadow cleared) and `frame` pulses 2 cycles later.
